data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised single-port data memory for the 16-bit CPU datapath, next generation of the fixed DM.
//  Adds req/ack handshake with configurable read wait states, byte-lane write enables,
//  out-of-range detection and a post-reset init sequencer that clears the array one word per cycle.
//  Sits between the CPU memory stage and the data store; the CPU stalls while ack is low.
// PARAMETERS
//  DW     16   data width in bits; must be a multiple of 8
//  AW     8    address width in bits
//  DEPTH  256  number of words implemented; must be <= 2**AW
//  WAIT   1    read wait states, range 0..7
// PORTS
//  clk    in   1      clock, all state on rising edge
//  reset  in   1      asynchronous, active-high
//  req    in   1      transaction request, sampled only in IDLE
//  we     in   1      1 = write, 0 = read; sampled with req
//  be     in   DW/8   byte-lane write enables, be[i] selects din[8i+7:8i]; ignored on reads
//  addr   in   AW     word address, sampled with req
//  din    in   DW     write data, sampled with req
//  dout   out  DW     read data, registered; valid while ack=1 for a read; holds until next read completes
//  ack    out  1      one-cycle completion pulse
//  err    out  1      valid with ack: 1 = addr >= DEPTH
//  busy   out  1      1 while in reset or INIT
// BEHAVIOUR
//  Reset values: dout=0, ack=0, err=0, busy=1, state=INIT, init index=0, wait count=0.
//  Reset asserted at any time, including mid-transaction, aborts the transaction with no ack and restarts INIT.
//  States:
//  - INIT: writes init value to mem[idx] and increments idx each cycle. After idx=DEPTH-1 the next state is IDLE and busy=0.
//    INIT lasts exactly DEPTH cycles. req is ignored and is never acked.
//  - IDLE: a req=1 at a rising edge is accepted, and addr/we/be/din are latched.
//    Write in range: at the same edge, every lane with be[i]=1 is updated. Lanes with be[i]=0 keep their value. be=0 is a legal no-op write. Next state is ACK.
//    Read: wait count is loaded with WAIT. Next state is RWAIT if WAIT>0, otherwise ACK; in the WAIT=0 case dout is loaded at the same edge.
//  - RWAIT: the count decrements each cycle. At the edge where count==1, dout is loaded from mem[latched addr] and the next state is ACK.
//  - ACK: ack=1 for exactly one cycle, with err valid, then IDLE. A req held high during ACK is not accepted in that cycle.
//  Latency, counted from the accepting edge to ack high:
//  - write: 1 cycle
//  - read: WAIT+1 cycles
//  Maximum throughput: one transaction per WAIT+2 cycles for reads and per 2 cycles for writes.
//  Out-of-range (addr >= DEPTH): a write modifies nothing; a read loads dout=0; err=1 with ack. No wrap-around.
//  Only one transaction is ever outstanding. Changes to inputs after acceptance have no effect.
//  Read-after-write to the same address returns the new data.
//  The memory array itself is not asynchronously reset; only INIT initialises it.
// CONFIGURATION
//  DM_BOOT_IMAGE_EN defined: INIT writes the boot image to words 0..10 and zero to all other words:
//    000a 02cd 0059 0059 0102 0048 0000 0100 10c3 00cd 0559
//    Requires DEPTH >= 11.
//  DM_BOOT_IMAGE_EN undefined: INIT writes zero to every word. Timing is identical in both cases (DEPTH cycles).
// TESTING
//  1. Reset pulse with DEPTH=256: busy=1 for 256 cycles after release. A req during INIT gives no ack. Afterwards a read of addr 5 returns 0000 (macro off) or 0048 (macro on).
//  2. WAIT=0: write 16'hBEEF to addr 3 with be=2'b11, then read addr 3. Write ack arrives 1 cycle after accept, read ack 1 cycle after accept, and dout=BEEF.
//  3. Byte lanes: preload 16'h1234, write 16'hABCD with be=2'b01, then read. Expect 12CD. With be=2'b00 the value is unchanged.
//  4. WAIT=3: read accepted at edge N gives ack high exactly in cycle N+4. ack lasts one cycle. Holding req high gives the next accept at N+5.
//  5. DEPTH=200, AW=8: write to addr 220 gives err=1 with ack and mem unchanged. Read of addr 220 gives dout=0 and err=1.
//  6. Assert reset during RWAIT: no ack, dout=0 and busy=1 immediately. INIT reruns in full and the array is reinitialised.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with req/ack handshake, read wait states,
// byte-lane writes, out-of-range detection and a post-reset INIT sweep.
// Ports: clk, reset (async, active-high), req_i, we_i, be_i, addr_i,
//   din_i -> dout_o, ack_o, err_o, busy_o.
// Option: define DM_BOOT_IMAGE_EN to load a boot image into words 0..10
//   during INIT (otherwise every word is cleared). Needs DEPTH >= 11.
module data_mem_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   din_i,
  output logic [DW-1:0]   dout_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int NB = DW / 8;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RWAIT,
    S_ACK
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] addr_q;
  logic          oor_q;
  logic [2:0]    cnt_q;
  logic [DW-1:0] dout_q;
  logic          ack_q;
  logic          err_q;
  logic          busy_q;

  logic [DW-1:0] mem [DEPTH];

  function automatic logic [DW-1:0] init_word(
    input logic [AW-1:0] i
  );
`ifdef DM_BOOT_IMAGE_EN
    logic [15:0] w;
    case (int'(i))
      0:       w = 16'h000a;
      1:       w = 16'h02cd;
      2:       w = 16'h0059;
      3:       w = 16'h0059;
      4:       w = 16'h0102;
      5:       w = 16'h0048;
      6:       w = 16'h0000;
      7:       w = 16'h0100;
      8:       w = 16'h10c3;
      9:       w = 16'h00cd;
      10:      w = 16'h0559;
      default: w = 16'h0000;
    endcase
    return DW'(w);
`else
    return (i == i) ? '0 : '0;
`endif
  endfunction

  logic in_rng_i;
  assign in_rng_i = ({1'b0, addr_i} < DEPTH_W);

  // The single write port is shared by the INIT sweep and CPU writes.
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = idx_q;
      mem_wdata = init_word(idx_q);
      mem_be    = '1;
    end else if (state_q == S_IDLE && req_i
                 && we_i && in_rng_i) begin
      mem_we    = 1'b1;
      mem_idx   = addr_i;
      mem_wdata = din_i;
      mem_be    = be_i;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i])
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Zero-wait reads sample the live address at the accept edge;
  // waited reads use the latched one.
  logic [AW-1:0] rd_addr;
  logic          rd_ok;
  logic [DW-1:0] rd_word;

  assign rd_addr = (state_q == S_IDLE) ? addr_i : addr_q;
  assign rd_ok   = (state_q == S_IDLE) ? in_rng_i : !oor_q;
  assign rd_word = rd_ok ? mem[rd_addr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            oor_q  <= !in_rng_i;
            cnt_q  <= 3'(WAIT);
            if (we_i || WAIT == 0) begin
              if (!we_i)
                dout_q <= rd_word;
              ack_q   <= 1'b1;
              err_q   <= !in_rng_i;
              state_q <= S_ACK;
            end else begin
              state_q <= S_RWAIT;
            end
          end
        end
        S_RWAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 3'd1) begin
            dout_q  <= rd_word;
            ack_q   <= 1'b1;
            err_q   <= oor_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign dout_o = dout_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: two instances
// (DEPTH=256/WAIT=0 and DEPTH=200/WAIT=3) against an array model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req  [2];
  logic        we   [2];
  logic [1:0]  be   [2];
  logic [7:0]  addr [2];
  logic [15:0] din  [2];
  logic [15:0] dout [2];
  logic        ack  [2];
  logic        err  [2];
  logic        busy [2];

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [2][256];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DW(16), .AW(8), .DEPTH(256), .WAIT(0)) u0 (
    .clk(clk), .reset(reset),
    .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .din_i(din[0]),
    .dout_o(dout[0]), .ack_o(ack[0]),
    .err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_ctrl #(.DW(16), .AW(8), .DEPTH(200), .WAIT(3)) u1 (
    .clk(clk), .reset(reset),
    .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .din_i(din[1]),
    .dout_o(dout[1]), .ack_o(ack[1]),
    .err_o(err[1]), .busy_o(busy[1])
  );

  function automatic int dep(int d);
    return (d == 0) ? 256 : 200;
  endfunction

  function automatic int wt(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [15:0] init_val(int i);
`ifdef DM_BOOT_IMAGE_EN
    logic [15:0] img [11];
    img = '{16'h000a, 16'h02cd, 16'h0059, 16'h0059,
            16'h0102, 16'h0048, 16'h0000, 16'h0100,
            16'h10c3, 16'h00cd, 16'h0559};
    return (i < 11) ? img[i] : 16'h0000;
`else
    return (i < 0) ? 16'hffff : 16'h0000;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++)
        mdl[d][i] = init_val(i);
      last_rd[d] = 16'h0;
    end
  endtask

  task automatic do_reset();
    int i, n0, n1, acks;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) req[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_init();
    chk("rst_busy0", busy[0], 1);
    chk("rst_busy1", busy[1], 1);
    chk("rst_dout1", dout[1], 0);
    chk("rst_ack1", ack[1], 0);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = 8'd5;
    end
    i = 0; n0 = 0; n1 = 0; acks = 0;
    while ((busy[0] || busy[1]) && i < 1000) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (ack[0] || ack[1]) acks++;
      if (i == 50) begin
        req[0] = 1'b0; req[1] = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    chk("init_len0", n0, 256);
    chk("init_len1", n1, 200);
    chk("init_noack", acks, 0);
  endtask

  task automatic txn(int d, bit w, bit [1:0] b,
                     bit [7:0] a, bit [15:0] v);
    int lat;
    bit seen, oor;
    oor = (int'(a) >= dep(d));
    req[d] = 1'b1; we[d] = w; be[d] = b;
    addr[d] = a; din[d] = v;
    @(posedge clk);
    if (w && !oor) begin
      for (int i = 0; i < 2; i++)
        if (b[i]) mdl[d][a][8*i +: 8] = v[8*i +: 8];
    end
    if (!w) last_rd[d] = oor ? 16'h0 : mdl[d][a];
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req[d] = 1'b0;
        we[d] = 1'($urandom);
        be[d] = 2'($urandom);
        addr[d] = 8'($urandom);
        din[d] = 16'($urandom);
      end
      if (ack[d]) seen = 1;
    end
    chk("ack_seen", seen, 1);
    chk(w ? "wr_lat" : "rd_lat", lat,
        w ? 1 : wt(d) + 1);
    chk("err", err[d], oor);
    chk("dout", dout[d], last_rd[d]);
    @(negedge clk);
    chk("ack_pulse", ack[d], 0);
  endtask

  task automatic hold_rd(int d, bit [7:0] a);
    int n, acks, first, second;
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
    @(posedge clk);
    n = 0; acks = 0; first = 0; second = 0;
    while (acks < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[d]) begin
        acks++;
        if (acks == 1) first = n;
        else second = n;
      end
    end
    req[d] = 1'b0;
    last_rd[d] = mdl[d][a];
    chk("hold_acks", acks, 2);
    chk("hold_first", first, wt(d) + 1);
    chk("hold_gap", second - first, wt(d) + 2);
    chk("hold_dout", dout[d], last_rd[d]);
    @(negedge clk);
  endtask

  initial begin
    int d, sel;
    bit [7:0] a;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; we[k] = 0; be[k] = 0;
      addr[k] = 0; din[k] = 0;
    end
    do_reset();

    txn(0, 0, 2'b00, 8'd5, 16'h0);
    chk("boot5", dout[0], init_val(5));
    txn(1, 0, 2'b00, 8'd5, 16'h0);

    txn(0, 1, 2'b11, 8'd3, 16'hBEEF);
    txn(0, 0, 2'b00, 8'd3, 16'h0);
    chk("beef", dout[0], 16'hBEEF);

    txn(0, 1, 2'b11, 8'd10, 16'h1234);
    txn(0, 1, 2'b01, 8'd10, 16'hABCD);
    txn(0, 0, 2'b00, 8'd10, 16'h0);
    chk("lane_lo", dout[0], 16'h12CD);
    txn(0, 1, 2'b00, 8'd10, 16'hFFFF);
    txn(0, 0, 2'b00, 8'd10, 16'h0);
    chk("lane_none", dout[0], 16'h12CD);
    txn(0, 1, 2'b10, 8'd10, 16'h5A00);
    txn(0, 0, 2'b00, 8'd10, 16'h0);

    txn(1, 1, 2'b11, 8'd7, 16'hC0DE);
    hold_rd(1, 8'd7);
    hold_rd(0, 8'd10);

    txn(1, 1, 2'b11, 8'd199, 16'h7777);
    txn(1, 1, 2'b11, 8'd220, 16'h5555);
    txn(1, 1, 2'b11, 8'd200, 16'h6666);
    txn(1, 0, 2'b00, 8'd220, 16'h0);
    txn(1, 0, 2'b00, 8'd199, 16'h0);
    txn(1, 0, 2'b00, 8'd20, 16'h0);
    txn(0, 1, 2'b11, 8'd255, 16'h9999);
    txn(0, 0, 2'b00, 8'd255, 16'h0);

    for (int k = 0; k < 150; k++) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 2));
      if (sel == 0) a = 8'($urandom_range(0, 15));
      else if (sel == 1) a = 8'($urandom_range(190, 215));
      else a = 8'($urandom);
      txn(d, 1'($urandom), 2'($urandom), a,
          16'($urandom));
    end

    txn(1, 1, 2'b11, 8'd3, 16'hBEEF);
    txn(1, 0, 2'b00, 8'd3, 16'h0);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'd3;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_dout", dout[1], 0);
    chk("mid_busy", busy[1], 1);
    chk("mid_ack", ack[1], 0);
    do_reset();
    txn(1, 0, 2'b00, 8'd3, 16'h0);
    chk("reinit3", dout[1], init_val(3));
    txn(0, 0, 2'b00, 8'd10, 16'h0);
    chk("reinit10", dout[0], init_val(10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
